// File: rtl/cic_comp_fir_if.sv
`default_nettype none
// ============================================================================
//  Module   : cic_comp_fir_if
//  Purpose  : Sample, coefficient-load and result bundle for cic_comp_fir.
//             The master drives samples and coefficients; the slave returns
//             results and status.
//  Revision : 1.0  initial release
// ============================================================================
interface cic_comp_fir_if #(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 24,
  parameter int COEFF_WIDTH = 18,
  parameter int NTAPS       = 32
);
  localparam int c_addr_w = $clog2(NTAPS);

  logic                          in_strobe;
  logic signed [IN_WIDTH-1:0]    in_data;
  logic                          coef_wr;
  logic [c_addr_w-1:0]           coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          ready;
  logic                          out_strobe;
  logic signed [OUT_WIDTH-1:0]   out_data;
  logic                          overrun;

  modport master (
    output in_strobe, in_data, coef_wr, coef_addr, coef_data,
    input  ready, out_strobe, out_data, overrun
  );

  modport slave (
    input  in_strobe, in_data, coef_wr, coef_addr, coef_data,
    output ready, out_strobe, out_data, overrun
  );
endinterface
`default_nettype wire

// File: rtl/cic_comp_fir.sv
`default_nettype none
// ============================================================================
//  Module   : cic_comp_fir
//  Purpose  : Decimate-by-2 CIC droop-compensation FIR. One time-shared MAC
//             walks a circular sample history against a loadable coefficient
//             RAM; the sum is rounded half-up, shifted and saturated.
//  Revision : 1.0  initial release
// ============================================================================
module cic_comp_fir #(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 24,
  parameter int COEFF_WIDTH = 18,
  parameter int NTAPS       = 32,
  parameter int SHIFT       = COEFF_WIDTH - 1
) (
  input  wire logic     clock,
  input  wire logic     reset,
  cic_comp_fir_if.slave bus
);
  localparam int c_addr_w   = $clog2(NTAPS);
  localparam int c_cnt_w    = c_addr_w + 1;
  localparam int c_prod_w   = IN_WIDTH + COEFF_WIDTH;
  localparam int c_acc_w    = c_prod_w + c_addr_w;
  localparam int c_mac_last = NTAPS + 1;  // last read + one MAC-register drain cycle

  localparam logic [1:0] c_st_clear = 2'd0;
  localparam logic [1:0] c_st_idle  = 2'd1;
  localparam logic [1:0] c_st_mac   = 2'd2;
  localparam logic [1:0] c_st_out   = 2'd3;

  localparam logic signed [c_acc_w:0] c_rnd_half = {{c_acc_w{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [c_acc_w:0] c_out_max  =
    {{(c_acc_w - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [c_acc_w:0] c_out_min  =
    {{(c_acc_w - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [IN_WIDTH-1:0]    hist_mem [NTAPS];
  logic signed [COEFF_WIDTH-1:0] coef_mem [NTAPS];

  logic [1:0]                    state_q, state_d;
  logic [c_cnt_w-1:0]            cnt_q, cnt_d;
  logic [c_addr_w-1:0]           wr_ptr_q, wr_ptr_d;
  logic [c_addr_w-1:0]           base_q, base_d;
  logic                          phase_q, phase_d;
  logic                          ready_q, ready_d;
  logic                          overrun_q, overrun_d;
  logic                          rd_vld_q, rd_vld_d;
  logic signed [COEFF_WIDTH-1:0] coef_rd_q, coef_rd_d;
  logic signed [IN_WIDTH-1:0]    hist_rd_q, hist_rd_d;
  logic signed [c_acc_w-1:0]     acc_q, acc_d;
  logic                          out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;

  logic                          w_accept, w_trigger, w_clear_done, w_mac_done;
  logic [c_addr_w-1:0]           w_k, w_rd_addr;
  logic                          w_hist_we;
  logic [c_addr_w-1:0]           w_hist_addr;
  logic signed [IN_WIDTH-1:0]    w_hist_wdata;
  logic signed [c_prod_w-1:0]    w_prod;
  logic signed [c_acc_w:0]       w_rnd_sum, w_rnd_shift;
  logic signed [OUT_WIDTH-1:0]   w_y;

  // Strobe qualification, tap walk addressing, history write port and output scaling
  always_comb begin
    w_accept     = bus.in_strobe && (state_q != c_st_clear);
    w_trigger    = w_accept && phase_q;
    w_clear_done = (cnt_q == c_cnt_w'(NTAPS - 1));
    w_mac_done   = (cnt_q == c_cnt_w'(c_mac_last));
    // Oldest tap first: a sample arriving mid-MAC overwrites x[n-(NTAPS-1)],
    // which has already been consumed, so the next sample cannot corrupt the sum.
    w_k          = c_addr_w'(NTAPS - 1) - cnt_q[c_addr_w-1:0];
    w_rd_addr    = base_q - w_k;
    w_hist_we    = (state_q == c_st_clear) || w_accept;
    w_hist_addr  = (state_q == c_st_clear) ? cnt_q[c_addr_w-1:0] : wr_ptr_q;
    w_hist_wdata = (state_q == c_st_clear) ? '0 : bus.in_data;
    w_prod       = coef_rd_q * hist_rd_q;
    w_rnd_sum    = {acc_q[c_acc_w-1], acc_q} + c_rnd_half;
    w_rnd_shift  = w_rnd_sum >>> SHIFT;
    if (w_rnd_shift > c_out_max) begin
      w_y = c_out_max[OUT_WIDTH-1:0];
    end else if (w_rnd_shift < c_out_min) begin
      w_y = c_out_min[OUT_WIDTH-1:0];
    end else begin
      w_y = w_rnd_shift[OUT_WIDTH-1:0];
    end
  end

  // Coefficient RAM: writable in every state and deliberately untouched by reset
  always_ff @(posedge clock) begin
    if (bus.coef_wr) begin
      coef_mem[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Sample history RAM: zero-filled during CLEAR, then one write per accepted strobe
  always_ff @(posedge clock) begin
    if (w_hist_we) begin
      hist_mem[w_hist_addr] <= w_hist_wdata;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= c_st_clear;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      phase_q      <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      coef_rd_q    <= '0;
      hist_rd_q    <= '0;
      acc_q        <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      phase_q      <= phase_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      rd_vld_q     <= rd_vld_d;
      coef_rd_q    <= coef_rd_d;
      hist_rd_q    <= hist_rd_d;
      acc_q        <= acc_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_clear: if (w_clear_done) state_d = c_st_idle;
      c_st_idle:  if (w_trigger)    state_d = c_st_mac;
      c_st_mac:   if (w_mac_done)   state_d = c_st_out;
      default:                      state_d = c_st_idle;
    endcase
  end

  // Per-state counter, sample bookkeeping, MAC pipeline and result register updates
  always_comb begin
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    phase_d      = phase_q;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    rd_vld_d     = 1'b0;
    coef_rd_d    = coef_rd_q;
    hist_rd_d    = hist_rd_q;
    acc_d        = acc_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;

    if (w_accept) begin
      wr_ptr_d = wr_ptr_q + c_addr_w'(1);
      phase_d  = ~phase_q;
    end
    // A trigger while a result is still in flight is dropped and flagged
    if (w_trigger && ((state_q == c_st_mac) || (state_q == c_st_out))) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      c_st_clear: begin
        cnt_d = w_clear_done ? '0 : cnt_q + c_cnt_w'(1);
        if (w_clear_done) ready_d = 1'b1;
      end
      c_st_idle: begin
        if (w_trigger) begin
          base_d = wr_ptr_q;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      c_st_mac: begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (cnt_q < c_cnt_w'(NTAPS)) begin
          rd_vld_d  = 1'b1;
          coef_rd_d = coef_mem[w_k];
          hist_rd_d = hist_mem[w_rd_addr];
        end
        if (rd_vld_q) begin
          acc_d = acc_q + c_acc_w'(w_prod);
        end
        if (w_mac_done) begin
          out_data_d   = w_y;
          out_strobe_d = 1'b1;
          cnt_d        = '0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.ready      = ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.out_data   = out_data_q;
endmodule
`default_nettype wire

// File: tb/tb_cic_comp_fir.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_comp_fir
//  Purpose  : Self-checking bench for cic_comp_fir. A reference model keeps
//             its own history/coefficients and queues expected results and
//             trigger times; a monitor pops and compares on each out_strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cic_comp_fir;
  localparam int IN_WIDTH    = 24;
  localparam int OUT_WIDTH   = 24;
  localparam int COEFF_WIDTH = 18;
  localparam int NTAPS       = 32;
  localparam int SHIFT       = COEFF_WIDTH - 1;
  localparam int c_addr_w    = $clog2(NTAPS);
  localparam int c_latency   = NTAPS + 3;

  logic clock;
  logic reset;

  cic_comp_fir_if #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH), .NTAPS(NTAPS)
  ) bus ();

  cic_comp_fir #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
    .NTAPS(NTAPS), .SHIFT(SHIFT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int     n_chk = 0;
  int     n_err = 0;
  int     cyc   = 0;
  longint exp_q[$];
  int     lat_q[$];
  bit     sb_en;
  bit     m_ready;
  bit     prev_strobe = 1'b0;
  longint m_hist [NTAPS];
  longint m_coef [NTAPS];
  int     m_wp;
  bit     m_phase;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference convolution with round-half-up and saturation
  function automatic longint model_y(input int newest);
    longint acc, y, y_max, y_min;
    acc   = 0;
    y_max = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    y_min = -(longint'(1) <<< (OUT_WIDTH - 1));
    for (int k = 0; k < NTAPS; k++)
      acc += m_coef[k] * m_hist[(newest - k + NTAPS) % NTAPS];
    y = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (y > y_max) y = y_max;
    else if (y < y_min) y = y_min;
    return y;
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin
    longint e;
    int     t;
    if (!reset) begin
      if (bus.out_strobe) begin
        check_eq("strobe_gap", longint'(prev_strobe), 0);
        if (sb_en) begin
          check_eq("sb_pending", longint'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = lat_q.pop_front();
            check_eq("out_data", longint'(bus.out_data), e);
            check_eq("latency", longint'(cyc - t), c_latency);
          end
        end
      end
      prev_strobe = bus.out_strobe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic send(input int val, input int gap);
    int  newest;
    bit  trig;
    @(negedge clock);
    bus.in_strobe = 1'b1;
    bus.in_data   = IN_WIDTH'(val);
    if (m_ready) begin
      newest         = m_wp;
      m_hist[m_wp]   = longint'(val);
      m_wp           = (m_wp + 1) % NTAPS;
      trig           = m_phase;
      m_phase        = ~m_phase;
      if (trig && sb_en) begin
        exp_q.push_back(model_y(newest));
        lat_q.push_back(cyc);
      end
    end
    @(negedge clock);
    bus.in_strobe = 1'b0;
    repeat (gap - 2) @(negedge clock);
  endtask

  task automatic load_coef(input int k, input int val);
    @(negedge clock);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = c_addr_w'(k);
    bus.coef_data = COEFF_WIDTH'(val);
    m_coef[k]     = longint'(val);
    @(negedge clock);
    bus.coef_wr   = 1'b0;
  endtask

  task automatic assert_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_ready",      longint'(bus.ready), 0);
    check_eq("rst_overrun",    longint'(bus.overrun), 0);
    check_eq("rst_out_strobe", longint'(bus.out_strobe), 0);
    check_eq("rst_out_data",   longint'(bus.out_data), 0);
    repeat (3) @(negedge clock);
    m_ready = 1'b0;
    m_wp    = 0;
    m_phase = 1'b0;
    for (int i = 0; i < NTAPS; i++) m_hist[i] = 0;
    exp_q.delete();
    lat_q.delete();
  endtask

  // Release reset and time ready; optionally pulse in_strobe while clearing
  task automatic release_reset(input bit pulse);
    int n;
    n = 100;
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      bus.in_strobe = pulse && (i == 3 || i == 8 || i == 13);
      bus.in_data   = IN_WIDTH'(500000);
      if (bus.ready) begin
        n = i;
        break;
      end
    end
    bus.in_strobe = 1'b0;
    check_eq("ready_latency", longint'(n), NTAPS);
    m_ready = 1'b1;
  endtask

  task automatic run_impulse();
    for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
    send(131072, 20);
    repeat (39) send(0, 20);
    repeat (60) @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    sb_en         = 1'b1;
    m_ready       = 1'b0;
    for (int i = 0; i < NTAPS; i++) m_coef[i] = 0;

    assert_reset();
    release_reset(1'b0);

    // Impulse response
    run_impulse();

    // DC gain
    for (int k = 0; k < NTAPS; k++) load_coef(k, 4096);
    repeat (40) send(1000, 20);
    repeat (60) @(negedge clock);

    // Saturation, both rails
    for (int k = 0; k < NTAPS; k++) load_coef(k, 131071);
    repeat (40) send(8388607, 20);
    repeat (40) send(-8388608, 20);
    repeat (60) @(negedge clock);
    check_eq("overrun_clear", longint'(bus.overrun), 0);

    // Overrun from a too-fast strobe rate
    sb_en = 1'b0;
    repeat (8) send(12345, 10);
    repeat (60) @(negedge clock);
    check_eq("overrun_set", longint'(bus.overrun), 1);
    repeat (100) @(negedge clock);
    check_eq("overrun_sticky", longint'(bus.overrun), 1);

    // Reset ten cycles into a MAC, strobes during CLEAR, retained coefficients
    for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
    if (!m_phase) send(0, 20);
    send(777, 2);
    repeat (9) @(negedge clock);
    assert_reset();
    sb_en = 1'b1;
    release_reset(1'b1);
    send(131072, 20);
    repeat (39) send(0, 20);
    repeat (60) @(negedge clock);

    check_eq("sb_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
